// File: rtl/data_cache_pkg.sv
// Shared types and constants for the direct-mapped write-through data cache.
package data_cache_pkg;

    localparam int DATA_WIDTH    = 32;
    localparam int ADDRESS_WIDTH = 32;
    localparam int INDEX_WIDTH   = 6;
    localparam int NUM_LINES     = 2 ** INDEX_WIDTH;

    // Tag bits left after removing the line index and the byte offset within a word.
    function automatic int tag_width(input int addr_w, input int index_w);
        return addr_w - index_w - 2;
    endfunction

    localparam int TAG_WIDTH = tag_width(ADDRESS_WIDTH, INDEX_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE
    } state_t;

    // funct3 encodings for load/store width
    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

endpackage

// File: rtl/data_cache_if.sv
// CPU memory-stage and backing-memory signals of the data cache.
interface data_cache_if;
    import data_cache_pkg::*;

    // CPU side
    logic [ADDRESS_WIDTH-1:0] a;
    logic                     re;
    logic                     we;
    logic [DATA_WIDTH-1:0]    writedata;
    logic [2:0]               memcontrol;
    logic [DATA_WIDTH-1:0]    readdata;
    logic                     stall;

    // Backing-memory side
    logic                     mem_req;
    logic                     mem_we;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]    mem_wdata;
    logic [3:0]               mem_be;
    logic                     mem_ack;
    logic [DATA_WIDTH-1:0]    mem_rdata;

    // The cache itself
    modport slave (
        input  a, re, we, writedata, memcontrol, mem_ack, mem_rdata,
        output readdata, stall, mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    // Pipeline plus backing memory driving the cache
    modport master (
        output a, re, we, writedata, memcontrol, mem_ack, mem_rdata,
        input  readdata, stall, mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

endinterface

// File: rtl/data_cache_ls_align.sv
// Byte-lane handling: load extract with sign/zero extension, store lane
// replication and byte-enable generation. Purely combinational.
module data_cache_ls_align
    import data_cache_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] ld_word_i,
    input  logic [1:0]            ld_off_i,
    input  logic [2:0]            ld_funct3_i,
    output logic [DATA_WIDTH-1:0] ld_data_o,
    input  logic [DATA_WIDTH-1:0] st_data_i,
    input  logic [1:0]            st_off_i,
    input  logic [2:0]            st_funct3_i,
    output logic [DATA_WIDTH-1:0] st_data_o,
    output logic [3:0]            st_be_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign ld_byte = ld_word_i[{ld_off_i, 3'b000} +: 8];
    assign ld_half = ld_off_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];

    // Load extension; unknown encodings return the whole word
    always_comb begin
        ld_data_o = ld_word_i;
        case (ld_funct3_i)
            LS_B:    ld_data_o = {{24{ld_byte[7]}}, ld_byte};
            LS_BU:   ld_data_o = {24'b0, ld_byte};
            LS_H:    ld_data_o = {{16{ld_half[15]}}, ld_half};
            LS_HU:   ld_data_o = {16'b0, ld_half};
            LS_W:    ld_data_o = ld_word_i;
            default: ld_data_o = ld_word_i;
        endcase
    end

    // Store data is replicated across lanes so memory only needs the enables
    always_comb begin
        st_data_o = st_data_i;
        st_be_o   = 4'b1111;
        case (st_funct3_i)
            LS_B: begin
                st_data_o = {4{st_data_i[7:0]}};
                st_be_o   = 4'b0001 << st_off_i;
            end
            LS_H: begin
                st_data_o = {2{st_data_i[15:0]}};
                st_be_o   = st_off_i[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_data_o = st_data_i;
                st_be_o   = 4'b1111;
            end
        endcase
    end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache, one word per line.
//
//   state | meaning
//   IDLE  | lookup; hits answer same cycle, misses and stores start a transaction
//   FILL  | read of the missed word outstanding on the backing memory
//   WRITE | write-through of a store outstanding on the backing memory
module data_cache
    import data_cache_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    data_cache_if.slave bus
);

    state_t                    state_q;
    logic [ADDRESS_WIDTH-1:0]  addr_q;
    logic [1:0]                off_q;
    logic [2:0]                funct3_q;
    logic [DATA_WIDTH-1:0]     wdata_q;
    logic [3:0]                be_q;
    logic                      mem_req_q;
    logic                      mem_we_q;

    logic [NUM_LINES-1:0]      valid_q;
    logic [TAG_WIDTH-1:0]      tag_q  [NUM_LINES];
    logic [DATA_WIDTH-1:0]     data_q [NUM_LINES];

    logic [INDEX_WIDTH-1:0]    idx;
    logic [TAG_WIDTH-1:0]      tag;
    logic                      hit;
    logic [INDEX_WIDTH-1:0]    q_idx;
    logic [TAG_WIDTH-1:0]      q_tag;
    logic                      q_hit;
    logic                      ack;

    logic [DATA_WIDTH-1:0]     ld_word;
    logic [1:0]                ld_off;
    logic [2:0]                ld_funct3;
    logic [DATA_WIDTH-1:0]     ld_data;
    logic                      ld_valid;
    logic [DATA_WIDTH-1:0]     st_data;
    logic [3:0]                st_be;
    logic [DATA_WIDTH-1:0]     merged;

    assign idx   = bus.a[INDEX_WIDTH+1:2];
    assign tag   = bus.a[ADDRESS_WIDTH-1:INDEX_WIDTH+2];
    assign hit   = valid_q[idx] && (tag_q[idx] == tag);

    assign q_idx = addr_q[INDEX_WIDTH+1:2];
    assign q_tag = addr_q[ADDRESS_WIDTH-1:INDEX_WIDTH+2];
    assign q_hit = valid_q[q_idx] && (tag_q[q_idx] == q_tag);

    // A stray ack with no request outstanding is ignored
    assign ack   = bus.mem_ack && mem_req_q;

    // Fill results are formatted with the request's latched offset and width
    assign ld_word   = (state_q == FILL) ? bus.mem_rdata : data_q[idx];
    assign ld_off    = (state_q == FILL) ? off_q         : bus.a[1:0];
    assign ld_funct3 = (state_q == FILL) ? funct3_q      : bus.memcontrol;
    assign ld_valid  = ((state_q == IDLE) && bus.re && !bus.we && hit) ||
                       ((state_q == FILL) && ack);

    data_cache_ls_align u_align (
        .ld_word_i   (ld_word),
        .ld_off_i    (ld_off),
        .ld_funct3_i (ld_funct3),
        .ld_data_o   (ld_data),
        .st_data_i   (bus.writedata),
        .st_off_i    (bus.a[1:0]),
        .st_funct3_i (bus.memcontrol),
        .st_data_o   (st_data),
        .st_be_o     (st_be)
    );

    // Byte merge of a write-through store into a resident line
    always_comb begin
        merged = data_q[q_idx];
        for (int i = 0; i < 4; i++) begin
            if (be_q[i]) begin
                merged[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end
    end

    // Stall whenever the pipeline must hold; released in the ack cycle
    always_comb begin
        bus.stall = 1'b0;
        case (state_q)
            IDLE:    bus.stall = bus.we || (bus.re && !hit);
            FILL,
            WRITE:   bus.stall = !ack;
            default: bus.stall = 1'b0;
        endcase
    end

    assign bus.readdata  = ld_valid ? ld_data : '0;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_be    = be_q;

    // Controller FSM with registered backing-memory request and valid bits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            off_q     <= '0;
            funct3_q  <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            valid_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.we) begin
                        state_q   <= WRITE;
                        addr_q    <= {bus.a[ADDRESS_WIDTH-1:2], 2'b00};
                        wdata_q   <= st_data;
                        be_q      <= st_be;
                        mem_req_q <= 1'b1;
                        mem_we_q  <= 1'b1;
                    end else if (bus.re && !hit) begin
                        state_q   <= FILL;
                        addr_q    <= {bus.a[ADDRESS_WIDTH-1:2], 2'b00};
                        off_q     <= bus.a[1:0];
                        funct3_q  <= bus.memcontrol;
                        be_q      <= '0;
                        mem_req_q <= 1'b1;
                        mem_we_q  <= 1'b0;
                    end
                end
                FILL: begin
                    if (ack) begin
                        state_q        <= IDLE;
                        mem_req_q      <= 1'b0;
                        valid_q[q_idx] <= 1'b1;
                    end
                end
                WRITE: begin
                    if (ack) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                end
            endcase
        end
    end

    // Tag/data storage; no reset needed because valid gates every use
    always_ff @(posedge clk) begin
        if ((state_q == FILL) && ack) begin
            tag_q[q_idx]  <= q_tag;
            data_q[q_idx] <= bus.mem_rdata;
        end else if ((state_q == WRITE) && ack && q_hit) begin
            data_q[q_idx] <= merged;
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: the bench plays both pipeline and backing memory.
module tb_data_cache;
    import data_cache_pkg::*;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    data_cache_if bus ();

    data_cache dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.re         = 1'b0;
        bus.we         = 1'b0;
        bus.a          = '0;
        bus.writedata  = '0;
        bus.memcontrol = LS_W;
        bus.mem_ack    = 1'b0;
        bus.mem_rdata  = '0;
    endtask

    // Load expected to hit: answered the same cycle, no backing request
    task automatic load_hit(input logic [31:0] addr, input logic [2:0] f3,
                            input logic [31:0] exp, input string name);
        @(posedge clk); #1;
        bus.a = addr; bus.re = 1'b1; bus.we = 1'b0; bus.memcontrol = f3;
        @(negedge clk);
        check({name, "_stall"}, {31'b0, bus.stall}, 32'd0);
        check({name, "_data"}, bus.readdata, exp);
        @(posedge clk); #1;
        bus.re = 1'b0;
        @(negedge clk);
        check({name, "_noreq"}, {31'b0, bus.mem_req}, 32'd0);
    endtask

    // Load expected to miss; memory acks after wait_n stalled FILL cycles
    task automatic load_miss(input logic [31:0] addr, input logic [2:0] f3, input int wait_n,
                             input logic [31:0] rdata, input logic [31:0] exp, input string name);
        @(posedge clk); #1;
        bus.a = addr; bus.re = 1'b1; bus.we = 1'b0; bus.memcontrol = f3;
        @(negedge clk);
        check({name, "_idle_stall"}, {31'b0, bus.stall}, 32'd1);
        check({name, "_idle_req"}, {31'b0, bus.mem_req}, 32'd0);
        @(posedge clk); #1;
        for (int i = 0; i < wait_n; i++) begin
            @(negedge clk);
            check({name, "_req"}, {31'b0, bus.mem_req}, 32'd1);
            check({name, "_we"}, {31'b0, bus.mem_we}, 32'd0);
            check({name, "_addr"}, bus.mem_addr, {addr[31:2], 2'b00});
            check({name, "_stall"}, {31'b0, bus.stall}, 32'd1);
            @(posedge clk); #1;
        end
        bus.mem_ack = 1'b1; bus.mem_rdata = rdata;
        @(negedge clk);
        check({name, "_ack_stall"}, {31'b0, bus.stall}, 32'd0);
        check({name, "_ack_data"}, bus.readdata, exp);
        @(posedge clk); #1;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0; bus.re = 1'b0;
        @(negedge clk);
        check({name, "_done"}, {31'b0, bus.mem_req}, 32'd0);
    endtask

    // Store (optionally with re also raised); memory acks after wait_n stalled WRITE cycles
    task automatic store(input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] f3,
                         input logic with_re, input int wait_n,
                         input logic [3:0] exp_be, input logic [31:0] exp_wdata, input string name);
        @(posedge clk); #1;
        bus.a = addr; bus.we = 1'b1; bus.re = with_re; bus.writedata = wd; bus.memcontrol = f3;
        @(negedge clk);
        check({name, "_idle_stall"}, {31'b0, bus.stall}, 32'd1);
        check({name, "_idle_rd"}, bus.readdata, 32'd0);
        @(posedge clk); #1;
        for (int i = 0; i <= wait_n; i++) begin
            if (i == wait_n) begin
                bus.mem_ack = 1'b1;
            end
            @(negedge clk);
            check({name, "_req"}, {31'b0, bus.mem_req}, 32'd1);
            check({name, "_we"}, {31'b0, bus.mem_we}, 32'd1);
            check({name, "_addr"}, bus.mem_addr, {addr[31:2], 2'b00});
            check({name, "_be"}, {28'b0, bus.mem_be}, {28'b0, exp_be});
            check({name, "_wdata"}, bus.mem_wdata, exp_wdata);
            check({name, "_stall"}, {31'b0, bus.stall}, (i == wait_n) ? 32'd0 : 32'd1);
            @(posedge clk); #1;
        end
        bus.mem_ack = 1'b0; bus.we = 1'b0; bus.re = 1'b0;
        @(negedge clk);
        check({name, "_done"}, {31'b0, bus.mem_req}, 32'd0);
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("rst_stall", {31'b0, bus.stall}, 32'd0);
        check("rst_readdata", bus.readdata, 32'd0);
        check("rst_mem_req", {31'b0, bus.mem_req}, 32'd0);
        check("rst_mem_we", {31'b0, bus.mem_we}, 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check("rst_mem_be", {28'b0, bus.mem_be}, 32'd0);
        @(negedge clk); @(negedge clk);
        #2 rst_n = 1'b1;

        // Idle with a stray ack: no effect
        @(posedge clk); #1;
        bus.mem_ack = 1'b1;
        @(negedge clk);
        check("idle_stall", {31'b0, bus.stall}, 32'd0);
        check("idle_readdata", bus.readdata, 32'd0);
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        @(negedge clk);
        check("stray_ack_req", {31'b0, bus.mem_req}, 32'd0);

        // Cold miss, then hits with every load width
        load_miss(32'h100, LS_W, 2, 32'hDEADBEEF, 32'hDEADBEEF, "cold_lw");
        load_hit(32'h100, LS_W, 32'hDEADBEEF, "hit_lw");
        load_hit(32'h103, LS_B, 32'hFFFFFFDE, "hit_lb");
        load_hit(32'h103, LS_BU, 32'h000000DE, "hit_lbu");
        load_hit(32'h102, LS_H, 32'hFFFFDEAD, "hit_lh");
        load_hit(32'h100, LS_HU, 32'h0000BEEF, "hit_lhu");

        // Store hits merge into the line
        store(32'h102, 32'h00001234, LS_H, 1'b0, 1, 4'b1100, 32'h12341234, "sh");
        load_hit(32'h100, LS_W, 32'h1234BEEF, "after_sh");
        store(32'h101, 32'h000000AB, LS_B, 1'b0, 0, 4'b0010, 32'hABABABAB, "sb");
        load_hit(32'h100, LS_W, 32'h1234ABEF, "after_sb");
        load_hit(32'h101, LS_B, 32'hFFFFFFAB, "after_sb_lb");

        // Store miss to the same index: written through, line left alone, no allocate
        store(32'h200, 32'hCAFEBABE, LS_W, 1'b0, 2, 4'b1111, 32'hCAFEBABE, "sw_miss");
        load_hit(32'h100, LS_W, 32'h1234ABEF, "line_kept");
        load_miss(32'h200, LS_W, 1, 32'hCAFEBABE, 32'hCAFEBABE, "no_alloc");

        // Conflict replacement on index 0
        load_miss(32'h500, LS_W, 1, 32'h55667788, 32'h55667788, "lw_500");
        load_hit(32'h502, LS_HU, 32'h00005566, "hit_500_lhu");
        load_miss(32'h100, LS_W, 0, 32'h1234ABEF, 32'h1234ABEF, "lw_100_again");

        // Fill result formatted with width and offset
        load_miss(32'h106, LS_H, 1, 32'h80017FFF, 32'hFFFF8001, "fill_lh");
        load_hit(32'h104, LS_B, 32'hFFFFFFFF, "hit_104_lb");

        // Store wins over a simultaneous load
        store(32'h100, 32'h0BADF00D, LS_W, 1'b1, 1, 4'b1111, 32'h0BADF00D, "we_prio");
        load_hit(32'h100, LS_W, 32'h0BADF00D, "after_prio");

        // Reset in the middle of a fill
        @(posedge clk); #1;
        bus.a = 32'h300; bus.re = 1'b1; bus.memcontrol = LS_W;
        @(negedge clk);
        check("rstfill_idle_stall", {31'b0, bus.stall}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("rstfill_req", {31'b0, bus.mem_req}, 32'd1);
        #1;
        rst_n = 1'b0; bus.re = 1'b0;
        #1;
        check("rstfill_req_drop", {31'b0, bus.mem_req}, 32'd0);
        check("rstfill_stall", {31'b0, bus.stall}, 32'd0);
        check("rstfill_addr", bus.mem_addr, 32'd0);
        #1 rst_n = 1'b1;
        load_miss(32'h300, LS_W, 1, 32'h00000077, 32'h00000077, "after_rst");
        load_miss(32'h100, LS_W, 0, 32'h0BADF00D, 32'h0BADF00D, "after_rst_100");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
